// File: rtl/branch_resolve_unit.sv
// Multi-cycle conditional-branch resolver: MSB-first chunked compare, flags, taken and next PC.
// Optional BRANCH_MISPREDICT_EN adds req_pred_taken / res_mispredict.
module branch_resolve_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_f3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_imm,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [5:0]      res_flags,
  output logic            res_taken,
  output logic [XLEN-1:0] res_target,
  output logic [XLEN-1:0] res_next_pc
`ifdef BRANCH_MISPREDICT_EN
  ,
  input  logic            req_pred_taken,
  output logic            res_mispredict
`endif
);

  localparam int unsigned NCHUNK = XLEN / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
  logic              res_valid_q, res_valid_d;
  logic [5:0]        res_flags_q, res_flags_d;
  logic              res_taken_q, res_taken_d;
  logic [XLEN-1:0]   res_target_q, res_target_d, res_next_pc_q, res_next_pc_d;
`ifdef BRANCH_MISPREDICT_EN
  logic              pred_q, pred_d, mis_q, mis_d;
`endif

  logic [31:0]       chunk_base;
  logic [CHUNK-1:0]  c1, c2;
  logic              fin_eq, fin_ltu, fin_lt, fin_taken;
  logic [XLEN-1:0]   sum_target, pc_plus4;

  assign chunk_base = CHUNK * 32'(idx_q);
  assign c1         = CHUNK'(rs1_q >> chunk_base);
  assign c2         = CHUNK'(rs2_q >> chunk_base);
  assign fin_eq     = (c1 == c2);
  assign fin_ltu    = (c1 < c2);
  // Differing sign bits decide the signed order on their own.
  assign fin_lt     = (rs1_q[XLEN-1] != rs2_q[XLEN-1]) ? rs1_q[XLEN-1] : fin_ltu;
  assign sum_target = pc_q + imm_q;
  assign pc_plus4   = pc_q + XLEN'(4);

  always_comb begin
    fin_taken = 1'b0;
    case (f3_q)
      3'b000:  fin_taken = fin_eq;
      3'b001:  fin_taken = !fin_eq;
      3'b100:  fin_taken = fin_lt;
      3'b101:  fin_taken = !fin_lt;
      3'b110:  fin_taken = fin_ltu;
      3'b111:  fin_taken = !fin_ltu;
      default: fin_taken = 1'b0;
    endcase
  end

  assign req_ready = (state_q == StIdle) && !flush;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    f3_d          = f3_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    res_valid_d   = res_valid_q;
    res_flags_d   = res_flags_q;
    res_taken_d   = res_taken_q;
    res_target_d  = res_target_q;
    res_next_pc_d = res_next_pc_q;
`ifdef BRANCH_MISPREDICT_EN
    pred_d        = pred_q;
    mis_d         = mis_q;
`endif
    if (flush) begin
      state_d     = StIdle;
      res_valid_d = 1'b0;
`ifdef BRANCH_MISPREDICT_EN
      mis_d       = 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            f3_d    = req_f3;
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
            pc_d    = req_pc;
            imm_d   = req_imm;
            idx_d   = IdxW'(NCHUNK - 1);
            state_d = StCmp;
`ifdef BRANCH_MISPREDICT_EN
            pred_d  = req_pred_taken;
`endif
          end
        end
        StCmp: begin
          // Finish on the first differing chunk, or after the last (LSB) chunk.
          if (!fin_eq || idx_q == '0) begin
            res_flags_d   = {!fin_ltu, fin_ltu, !fin_lt, fin_lt, !fin_eq, fin_eq};
            res_taken_d   = fin_taken;
            res_target_d  = sum_target;
            res_next_pc_d = fin_taken ? sum_target : pc_plus4;
            res_valid_d   = 1'b1;
            state_d       = StDone;
`ifdef BRANCH_MISPREDICT_EN
            mis_d         = fin_taken ^ pred_q;
`endif
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      f3_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      res_valid_q   <= 1'b0;
      res_flags_q   <= '0;
      res_taken_q   <= 1'b0;
      res_target_q  <= '0;
      res_next_pc_q <= '0;
`ifdef BRANCH_MISPREDICT_EN
      pred_q        <= 1'b0;
      mis_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      f3_q          <= f3_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      res_valid_q   <= res_valid_d;
      res_flags_q   <= res_flags_d;
      res_taken_q   <= res_taken_d;
      res_target_q  <= res_target_d;
      res_next_pc_q <= res_next_pc_d;
`ifdef BRANCH_MISPREDICT_EN
      pred_q        <= pred_d;
      mis_q         <= mis_d;
`endif
    end
  end

  assign res_valid   = res_valid_q;
  assign res_flags   = res_flags_q;
  assign res_taken   = res_taken_q;
  assign res_target  = res_target_q;
  assign res_next_pc = res_next_pc_q;
`ifdef BRANCH_MISPREDICT_EN
  assign res_mispredict = mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus randomized ops vs. a
// behavioural model. Define BRANCH_MISPREDICT_EN to cover the mispredict output.
module tb_branch_resolve_unit;
  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_f3 = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_pc = '0, req_imm = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [5:0]  res_flags;
  logic        res_taken;
  logic [31:0] res_target, res_next_pc;
`ifdef BRANCH_MISPREDICT_EN
  logic        req_pred_taken = 1'b0;
  logic        res_mispredict;
  logic        cap_mis;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Values captured by run_op
  int          cap_lat;
  logic [5:0]  cap_flags;
  logic        cap_taken, cap_changed, cap_busy, cap_timeout, cap_post_valid, cap_post_ready;
  logic [31:0] cap_tgt, cap_nxt;

  branch_resolve_unit #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_f3      (req_f3),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_pc      (req_pc),
    .req_imm     (req_imm),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_flags   (res_flags),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .res_next_pc (res_next_pc)
`ifdef BRANCH_MISPREDICT_EN
    ,
    .req_pred_taken (req_pred_taken),
    .res_mispredict (res_mispredict)
`endif
  );

  always #5 clk = ~clk;

  // Reference model straight from the ISA rules and the chunk-timing rule.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] imm,
                                output logic [5:0] flags, output logic taken,
                                output logic [31:0] tgt, output logic [31:0] nxt,
                                output int cyc);
    logic eq, ltu, lt, found;
    logic [31:0] x;
    eq  = (a == b);
    ltu = (a < b);
    lt  = ($signed(a) < $signed(b));
    flags = {!ltu, ltu, !lt, lt, !eq, eq};
    case (f3)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
    tgt = pc + imm;
    nxt = taken ? tgt : pc + 32'd4;
    x = a ^ b;
    cyc = NCHUNK;
    found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (x[i] && !found) begin
        cyc   = (XLEN - 1 - i) / CHUNK + 1;
        found = 1'b1;
      end
    end
  endfunction

  // Issue one request, wait for the result, hold res_ready low for 'hold' cycles, then accept.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm, input int hold);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    req_f3 = f3; req_rs1 = a; req_rs2 = b; req_pc = pc; req_imm = imm;
    req_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cap_lat = 0;
    while (!res_valid && cap_lat < 50) begin
      @(posedge clk); #1; cap_lat++;
    end
    cap_timeout = !res_valid;
    cap_flags = res_flags; cap_taken = res_taken; cap_tgt = res_target; cap_nxt = res_next_pc;
`ifdef BRANCH_MISPREDICT_EN
    cap_mis = res_mispredict;
`endif
    cap_busy = !req_ready;
    cap_changed = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || res_flags !== cap_flags || res_taken !== cap_taken ||
          res_target !== cap_tgt || res_next_pc !== cap_nxt || req_ready !== 1'b0)
        cap_changed = 1'b1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    cap_post_valid = res_valid;
    cap_post_ready = req_ready;
  endtask

  task automatic test_reset;
    #3;
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
    n_tests++; if (res_flags !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b exp 000000", res_flags); end
    n_tests++; if (res_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b exp 0", res_taken); end
    n_tests++; if (res_target !== 32'h0 || res_next_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pcs: got %h/%h exp 0/0", res_target, res_next_pc);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_beq;
    run_op(3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'h20, 0);
    n_tests++; if (cap_timeout !== 1'b0) begin n_fail++; $display("FAIL beq_timeout: got %b exp 0", cap_timeout); end
    n_tests++; if (cap_lat != 4) begin n_fail++; $display("FAIL beq_cycles: got %0d exp 4", cap_lat); end
    n_tests++; if (cap_flags !== 6'b101001) begin n_fail++; $display("FAIL beq_flags: got %b exp 101001", cap_flags); end
    n_tests++; if (cap_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b exp 1", cap_taken); end
    n_tests++; if (cap_tgt !== 32'h120 || cap_nxt !== 32'h120) begin
      n_fail++; $display("FAIL beq_pcs: got %h/%h exp 120/120", cap_tgt, cap_nxt);
    end
    n_tests++; if (cap_post_valid !== 1'b0 || cap_post_ready !== 1'b1) begin
      n_fail++; $display("FAIL beq_handshake: got valid=%b ready=%b exp 0/1", cap_post_valid, cap_post_ready);
    end
  endtask

  task automatic test_blt_bltu;
    run_op(3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h200, 32'h40, 0);
    n_tests++; if (cap_lat != 1) begin n_fail++; $display("FAIL blt_cycles: got %0d exp 1", cap_lat); end
    n_tests++; if (cap_flags !== 6'b100110) begin n_fail++; $display("FAIL blt_flags: got %b exp 100110", cap_flags); end
    n_tests++; if (cap_taken !== 1'b1 || cap_nxt !== 32'h240) begin
      n_fail++; $display("FAIL blt_taken: got %b/%h exp 1/00000240", cap_taken, cap_nxt);
    end
    run_op(3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h200, 32'h40, 0);
    n_tests++; if (cap_lat != 1) begin n_fail++; $display("FAIL bltu_cycles: got %0d exp 1", cap_lat); end
    n_tests++; if (cap_flags !== 6'b100110) begin n_fail++; $display("FAIL bltu_flags: got %b exp 100110", cap_flags); end
    n_tests++; if (cap_taken !== 1'b0 || cap_nxt !== 32'h204 || cap_tgt !== 32'h240) begin
      n_fail++; $display("FAIL bltu_not_taken: got %b/%h/%h exp 0/00000204/00000240", cap_taken, cap_nxt, cap_tgt);
    end
  endtask

  task automatic test_backpressure;
    run_op(3'b001, 32'h00000A00, 32'h00000B00, 32'h1000, 32'hFFFFFFF0, 10);
    n_tests++; if (cap_lat != 3) begin n_fail++; $display("FAIL bp_cycles: got %0d exp 3", cap_lat); end
    n_tests++; if (cap_flags !== 6'b010110) begin n_fail++; $display("FAIL bp_flags: got %b exp 010110", cap_flags); end
    n_tests++; if (cap_taken !== 1'b1 || cap_nxt !== 32'h0FF0) begin
      n_fail++; $display("FAIL bp_taken: got %b/%h exp 1/00000ff0", cap_taken, cap_nxt);
    end
    n_tests++; if (cap_busy !== 1'b1) begin n_fail++; $display("FAIL bp_req_ready_in_done: got busy=%b exp 1", cap_busy); end
    n_tests++; if (cap_changed !== 1'b0) begin n_fail++; $display("FAIL bp_stable: got changed=%b exp 0", cap_changed); end
    n_tests++; if (cap_post_valid !== 1'b0 || cap_post_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got valid=%b ready=%b exp 0/1", cap_post_valid, cap_post_ready);
    end
  endtask

  task automatic test_wrap;
    run_op(3'b010, 32'h5, 32'h5, 32'hFFFFFFFC, 32'h8, 1);
    n_tests++; if (cap_taken !== 1'b0) begin n_fail++; $display("FAIL wrap_taken: got %b exp 0", cap_taken); end
    n_tests++; if (cap_nxt !== 32'h0) begin n_fail++; $display("FAIL wrap_next_pc: got %h exp 00000000", cap_nxt); end
    n_tests++; if (cap_tgt !== 32'h4) begin n_fail++; $display("FAIL wrap_target: got %h exp 00000004", cap_tgt); end
    n_tests++; if (cap_flags !== 6'b101001) begin n_fail++; $display("FAIL wrap_flags: got %b exp 101001", cap_flags); end
  endtask

  task automatic test_flush;
    int seen;
    // Flush on the second CMP cycle
    req_f3 = 3'b000; req_rs1 = 32'hCAFE0000; req_rs2 = 32'hCAFE0000; req_pc = 32'h40; req_imm = 32'h8;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    #1;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_ready: got %b exp 0", req_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_after: got %b exp 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_result: got %0d valid cycles exp 0", seen); end
    // Flush in IDLE must block acceptance
    flush = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_accepted: got ready=%b exp 1", req_ready); end
    // Flush in DONE with res_ready high: no transfer, back to IDLE
`ifdef BRANCH_MISPREDICT_EN
    req_pred_taken = 1'b0;
`endif
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    while (!res_valid && seen < 50) begin
      @(posedge clk); #1; seen++;
    end
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL flush_done_setup: got valid=%b exp 1", res_valid); end
    flush = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; res_ready = 1'b0;
    #1;
    n_tests++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_done: got valid=%b ready=%b exp 0/1", res_valid, req_ready);
    end
`ifdef BRANCH_MISPREDICT_EN
    n_tests++; if (res_mispredict !== 1'b0) begin n_fail++; $display("FAIL flush_mispredict: got %b exp 0", res_mispredict); end
`endif
  endtask

  task automatic test_async_reset;
    int seen;
    run_op(3'b000, 32'h1, 32'h1, 32'h300, 32'h10, 0);
    req_f3 = 3'b001; req_rs1 = 32'h77; req_rs2 = 32'h77; req_pc = 32'h500; req_imm = 32'h4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (res_valid !== 1'b0 || res_flags !== 6'b0 || res_taken !== 1'b0 ||
                   res_target !== 32'h0 || res_next_pc !== 32'h0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got v=%b f=%b t=%b tg=%h np=%h rdy=%b exp 0/0/0/0/0/1",
               res_valid, res_flags, res_taken, res_target, res_next_pc, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL async_reset_no_result: got %0d exp 0", seen); end
  endtask

`ifdef BRANCH_MISPREDICT_EN
  task automatic test_mispredict;
    req_pred_taken = 1'b0;
    run_op(3'b000, 32'hABCD, 32'hABCD, 32'h80, 32'h10, 0);
    n_tests++; if (cap_mis !== 1'b1) begin n_fail++; $display("FAIL mispredict_pred0: got %b exp 1", cap_mis); end
    req_pred_taken = 1'b1;
    run_op(3'b000, 32'hABCD, 32'hABCD, 32'h80, 32'h10, 0);
    n_tests++; if (cap_mis !== 1'b0) begin n_fail++; $display("FAIL mispredict_pred1: got %b exp 0", cap_mis); end
  endtask
`endif

  task automatic test_random;
    logic [31:0] a, b, pc, imm, e_tgt, e_nxt;
    logic [2:0]  f3;
    logic [5:0]  e_flags;
    logic        e_taken;
    int          e_cyc, mode, j;
    for (int it = 0; it < 40; it++) begin
      a = $urandom; pc = $urandom; imm = $urandom; f3 = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 3);
      j = $urandom_range(0, NCHUNK - 1);
      case (mode)
        0:       b = a;
        1:       b = $urandom;
        2:       b = a ^ (32'($urandom_range(1, 255)) << (CHUNK * j));
        default: b = a ^ 32'h80000000;
      endcase
`ifdef BRANCH_MISPREDICT_EN
      req_pred_taken = 1'($urandom_range(0, 1));
`endif
      model(f3, a, b, pc, imm, e_flags, e_taken, e_tgt, e_nxt, e_cyc);
      run_op(f3, a, b, pc, imm, $urandom_range(0, 3));
      n_tests++; if (cap_lat != e_cyc) begin
        n_fail++; $display("FAIL rnd_cycles[%0d]: got %0d exp %0d (a=%h b=%h)", it, cap_lat, e_cyc, a, b);
      end
      n_tests++; if (cap_flags !== e_flags) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got %b exp %b (a=%h b=%h)", it, cap_flags, e_flags, a, b);
      end
      n_tests++; if (cap_taken !== e_taken || cap_tgt !== e_tgt || cap_nxt !== e_nxt) begin
        n_fail++;
        $display("FAIL rnd_branch[%0d]: got %b/%h/%h exp %b/%h/%h (f3=%b)", it, cap_taken, cap_tgt,
                 cap_nxt, e_taken, e_tgt, e_nxt, f3);
      end
      n_tests++; if (cap_changed !== 1'b0 || cap_post_ready !== 1'b1) begin
        n_fail++; $display("FAIL rnd_handshake[%0d]: got changed=%b ready=%b exp 0/1", it, cap_changed, cap_post_ready);
      end
`ifdef BRANCH_MISPREDICT_EN
      n_tests++; if (cap_mis !== (e_taken ^ req_pred_taken)) begin
        n_fail++; $display("FAIL rnd_mispredict[%0d]: got %b exp %b", it, cap_mis, e_taken ^ req_pred_taken);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_backpressure();
    test_wrap();
    test_flush();
    test_async_reset();
`ifdef BRANCH_MISPREDICT_EN
    test_mispredict();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
